// File: rtl/fp32_to_int32_seq.sv
// Iterative FP32 -> signed INT32 converter, truncating toward zero.
// Alignment uses a one-bit-per-cycle shifter, so latency depends on the exponent.
module fp32_to_int32_seq #(
  parameter logic [31:0] NAN_VALUE = 32'h7FFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_overflow,
  output logic        out_inexact
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic [31:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        inex_q, inex_d;

  logic        in_s;
  logic [7:0]  in_e;
  logic [22:0] in_m;

  assign in_s = in_data[31];
  assign in_e = in_data[30:23];
  assign in_m = in_data[22:0];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sign_d  = sign_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    inex_d  = inex_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_s;
          state_d = DONE;
          if (in_e == 8'd0) begin
            data_d = 32'h0;
            ovf_d  = 1'b0;
            inex_d = (in_m != 23'd0);
          end else if (in_e <= 8'd126) begin
            data_d = 32'h0;
            ovf_d  = 1'b0;
            inex_d = 1'b1;
          end else if (in_e == 8'd255 && in_m != 23'd0) begin
            data_d = NAN_VALUE;
            ovf_d  = 1'b1;
            inex_d = 1'b0;
          end else if (in_data == 32'hCF000000) begin
            // -2^31 is the one representable value at the saturation boundary
            data_d = 32'h80000000;
            ovf_d  = 1'b0;
            inex_d = 1'b0;
          end else if (in_e >= 8'd158) begin
            data_d = in_s ? 32'h80000000 : 32'h7FFFFFFF;
            ovf_d  = 1'b1;
            inex_d = 1'b0;
          end else begin
            mag_d   = {8'b0, 1'b1, in_m};
            inex_d  = 1'b0;
            state_d = SHIFT;
            if (in_e >= 8'd150) begin
              left_d = 1'b1;
              cnt_d  = 5'(in_e - 8'd150);
            end else begin
              left_d = 1'b0;
              cnt_d  = 5'(8'd150 - in_e);
            end
          end
        end
      end
      SHIFT: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          if (left_q) begin
            mag_d = {mag_q[30:0], 1'b0};
          end else begin
            mag_d  = {1'b0, mag_q[31:1]};
            inex_d = inex_q | mag_q[0];
          end
        end else begin
          data_d  = sign_q ? (~mag_q + 32'd1) : mag_q;
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mag_q   <= 32'h0;
      cnt_q   <= 5'd0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
      data_q  <= 32'h0;
      ovf_q   <= 1'b0;
      inex_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      inex_q  <= inex_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_data     = data_q;
  assign out_overflow = ovf_q;
  assign out_inexact  = inex_q;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Bench for fp32_to_int32_seq: directed corner cases, backpressure, reset abort and
// randomized operands checked against an arithmetic reference model.
module tb_fp32_to_int32_seq;

  localparam logic [31:0] NAN_VALUE = 32'h7FFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_inexact;

  int checks = 0;
  int fails  = 0;

  fp32_to_int32_seq #(.NAN_VALUE(NAN_VALUE)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value = 1.m * 2^(e-127); integer part truncated toward zero, saturate when |x| >= 2^31.
  function automatic void ref_model(input logic [31:0] x, output logic [31:0] d,
                                    output logic ov, output logic ix, output int lat);
    logic s;
    int e;
    logic [22:0] m;
    longint unsigned mant, mag;
    s = x[31];
    e = int'(x[30:23]);
    m = x[22:0];
    mant = 64'({1'b1, m});
    lat = 0;
    if (e == 255 && m != 23'd0) begin
      d = NAN_VALUE; ov = 1'b1; ix = 1'b0;
    end else if (e == 0) begin
      d = 32'h0; ov = 1'b0; ix = (m != 23'd0);
    end else if (e - 127 >= 31) begin
      ix = 1'b0;
      if (s && e == 158 && m == 23'd0) begin
        d = 32'h80000000; ov = 1'b0;
      end else begin
        d = s ? 32'h80000000 : 32'h7FFFFFFF; ov = 1'b1;
      end
    end else begin
      if (e >= 150) begin
        mag = mant << (e - 150);
        ix = 1'b0;
      end else begin
        mag = mant >> (150 - e);
        ix = (mant & ((64'd1 << (150 - e)) - 64'd1)) != 64'd0;
      end
      d = s ? 32'(-mag) : 32'(mag);
      ov = 1'b0;
      if (e >= 127) lat = ((e >= 150) ? (e - 150) : (150 - e)) + 1;
    end
  endfunction

  // Send one operand, check latency/result, optionally hold out_ready low for 'hold' cycles.
  task automatic run_op(input logic [31:0] x, input int hold, input string tag);
    logic [31:0] ed;
    logic eo, ei;
    int elat, n;
    ref_model(x, ed, eo, ei, elat);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid = 1'b1;
    in_data = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = $urandom;
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
      if (!out_valid && in_ready) check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    end
    check({tag, " latency"}, 32'(n), 32'(elat));
    check({tag, " data"}, out_data, ed);
    check({tag, " overflow"}, 32'(out_overflow), 32'(eo));
    check({tag, " inexact"}, 32'(out_inexact), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold data"}, out_data, ed);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid cleared"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    if (hold > 0) out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int n;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_data", out_data, 32'h0);
    check("reset overflow", 32'(out_overflow), 32'd0);
    check("reset inexact", 32'(out_inexact), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(32'h3F800000, 0, "one");
    run_op(32'hC2F60000, 10, "neg123");
    run_op(32'h4C000000, 10, "pow25");
    run_op(32'h40200000, 0, "two_half");
    run_op(32'h3F000000, 0, "half");
    run_op(32'h00000000, 0, "zero");
    run_op(32'h80000001, 2, "neg_subnormal");
    run_op(32'h4F000000, 0, "pow31");
    run_op(32'hCF000000, 0, "neg_pow31");
    run_op(32'hCF000001, 0, "below_neg_pow31");
    run_op(32'h4EFFFFFF, 0, "max_normal");
    run_op(32'hFF800000, 0, "neg_inf");
    run_op(32'h7FC00000, 0, "nan");
    run_op(32'h7F800000, 0, "pos_inf");

    // Back-to-back with out_ready held high
    run_op(32'h42F60000, 0, "b2b_a");
    run_op(32'hBFC00000, 0, "b2b_b");
    run_op(32'h4B000001, 0, "b2b_c");

    // Reset aborts an in-flight conversion
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abort no result", 32'(n), 32'd0);
    run_op(32'hC1200000, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (i % 2 == 0) r[30:23] = 8'($urandom_range(120, 160));
      run_op(r, int'($urandom_range(0, 3)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
